// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags derived
// from wrap-bit pointers.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  wr_acc, rd_acc;

    // The extra MSB separates "same slot, one lap apart" (full) from "same slot" (empty).
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    assign dout  = dout_q;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            dout_d   = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is never cleared; reset only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= din;
        end
    end
endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue model of FIFO contents feeds expected
// read data into a scoreboard at drive time; tests pop and compare after the edge.
module tb_sync_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en, rd_en;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          full, empty;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model[$];
    logic [DW-1:0] sb[$];

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
        .din(din), .dout(dout), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; outputs are sampled 1ns after the edge by callers.
    task automatic drive(input logic w, input logic r, input logic [DW-1:0] d, output logic racc);
        logic wacc;
        wacc = w && (model.size() < DEPTH);
        racc = r && (model.size() > 0);
        if (racc) sb.push_back(model[0]);
        wr_en = w; rd_en = r; din = d;
        @(posedge clk); #1;
        if (racc) model.delete(0);
        if (wacc) model.push_back(d);
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic apply_reset(input logic w, input logic r);
        reset = 1'b1; wr_en = w; rd_en = r; din = 8'hEE;
        @(posedge clk); #1;
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        model.delete(); sb.delete();
    endtask

    task automatic test_reset();
        logic racc;
        apply_reset(1'b1, 1'b1);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%0d exp=0", dout); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 8'h00, racc);
            checks++; if (dout !== 8'h00 || empty !== 1'b1 || racc) begin
                errors++; $display("FAIL rd_empty dout=%0d empty=%b exp dout=0 empty=1", dout, empty);
            end
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] vals [17] = '{45,73,34,94,5,23,87,72,11,41,66,21,88,50,28,32,11};
        logic racc;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, vals[i], racc);
            checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty i=%0d got=%b exp=0", i, empty); end
            checks++; if (full !== (i >= 15)) begin errors++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, (i >= 15)); end
        end
    endtask

    task automatic test_drain();
        logic [DW-1:0] exp;
        logic racc;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'h00, racc);
            if (racc) begin
                exp = sb.pop_front();
                checks++; if (dout !== exp) begin errors++; $display("FAIL drain_dout i=%0d got=%0d exp=%0d", i, dout, exp); end
            end
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL drain_full i=%0d got=%b exp=0", i, full); end
            checks++; if (empty !== (i == 15)) begin errors++; $display("FAIL drain_empty i=%0d got=%b exp=%b", i, empty, (i == 15)); end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 8'h00, racc);
            checks++; if (dout !== 8'd32 || empty !== 1'b1) begin
                errors++; $display("FAIL drain_extra dout=%0d empty=%b exp dout=32 empty=1", dout, empty);
            end
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] exp;
        logic racc;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, DW'(100 + i), racc);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 8'h00, racc);
            if (racc) begin
                exp = sb.pop_front();
                checks++; if (dout !== exp) begin errors++; $display("FAIL wrap_pre i=%0d got=%0d exp=%0d", i, dout, exp); end
            end
        end
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, DW'(i), racc);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL wrap_full got=%b exp=1", full); end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'h00, racc);
            exp = racc ? sb.pop_front() : 8'hxx;
            checks++; if (dout !== exp || exp !== DW'(i)) begin
                errors++; $display("FAIL wrap_rd i=%0d got=%0d exp=%0d", i, dout, i);
            end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", empty); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp;
        logic racc;
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, DW'(8'h20 + i), racc);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, DW'(8'h40 + i), racc);
            exp = racc ? sb.pop_front() : 8'hxx;
            checks++; if (dout !== exp) begin errors++; $display("FAIL b2b_dout i=%0d got=%0d exp=%0d", i, dout, exp); end
            checks++; if (full !== 1'b0 || empty !== 1'b0 || model.size() != 8) begin
                errors++; $display("FAIL b2b_flags i=%0d full=%b empty=%b exp 0/0", i, full, empty);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic racc;
        apply_reset(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, DW'(8'h60 + i), racc);
        apply_reset(1'b1, 1'b1);
        checks++; if (empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00) begin
            errors++; $display("FAIL mid_reset empty=%b full=%b dout=%0d exp 1/0/0", empty, full, dout);
        end
        drive(1'b1, 1'b0, 8'hAB, racc);
        drive(1'b0, 1'b1, 8'h00, racc);
        checks++; if (dout !== 8'hAB || !racc || sb.pop_front() !== 8'hAB) begin
            errors++; $display("FAIL mid_new got=%h exp=ab", dout);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got=%b exp=1", empty); end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
